// File: rtl/led_pkg.sv
// Shared definitions for the LED counter: display mode codes, bounce direction
// and the Gray encoder used by the GRAY display mode.
package led_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_GRAY   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  // Operates on a full 32-bit word so callers of any WIDTH up to 32 can
  // zero-extend in and truncate out; the high zero bits do not disturb the
  // low bits of the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler for the LED counter.
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset, clears the prescaler
//  en   : prescaler advances only while high
//  clr  : synchronous clear (driven by load), restarts the step period
//  tick : high in the cycle whose rising edge takes a step
//         (combinational: en && pre == STEP_CYCLES-1)
module led_tick_gen #(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(STEP_CYCLES - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) pre <= '0;
    else if (en)    pre <= (pre == LAST) ? '0 : pre + 1'b1;
  end

endmodule

// File: rtl/led_counter_multi.sv
// Multi-mode LED counter: steps a WIDTH-bit LED pattern every STEP_CYCLES clocks.
//  clk      : rising-edge clock
//  rst      : synchronous active-high reset
//  en       : 1 = prescaler runs, 0 = prescaler and state hold
//  mode     : 0 UP, 1 DOWN, 2 GRAY, 3 BOUNCE
//  load     : single-cycle strobe, cnt <= load_val (beats a coincident step)
//  load_val : value taken by load
//  leds     : registered LED pattern, encoding of the current state in 'mode'
//  step     : 1-cycle pulse in the cycle a stepped leds value is visible
//  wrap     : 1-cycle pulse with step on counter wrap or bounce reversal
module led_counter_multi
  import led_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int STEP_CYCLES = CLK_FREQ / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             step,
  output logic             wrap
);

  localparam int PW = $clog2(WIDTH);
  localparam logic [PW-1:0] LASTP = PW'(WIDTH - 1);

  logic             tick;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [PW-1:0]    pos, pos_n;
  dir_t             dir, dir_n;
  logic             wrap_n;

  led_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  function automatic logic [WIDTH-1:0] encode(input logic [1:0] m,
                                              input logic [WIDTH-1:0] c,
                                              input logic [PW-1:0] p);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_GRAY:   r = WIDTH'(bin2gray(32'(c)));
      MODE_BOUNCE: r = WIDTH'(1) << p;
      default:     r = c;
    endcase
    return r;
  endfunction

  // Next state for a step; cnt only moves in counting modes, pos/dir only in BOUNCE.
  always_comb begin
    cnt_n  = cnt;
    pos_n  = pos;
    dir_n  = dir;
    wrap_n = 1'b0;
    if (tick) begin
      case (mode)
        MODE_DOWN: begin
          cnt_n  = cnt - 1'b1;
          wrap_n = (cnt == '0);
        end
        MODE_BOUNCE: begin
          // At an end, reverse and move one place back the other way.
          if (dir == DIR_UP) begin
            if (pos == LASTP) begin
              pos_n  = pos - 1'b1;
              dir_n  = DIR_DOWN;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              pos_n  = pos + 1'b1;
              dir_n  = DIR_UP;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos - 1'b1;
            end
          end
        end
        default: begin
          cnt_n  = cnt + 1'b1;
          wrap_n = (cnt == '1);
        end
      endcase
    end
  end

  // leds is re-encoded every cycle, so a mode change shows on the next edge
  // even while en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pos  <= '0;
      dir  <= DIR_UP;
      step <= 1'b0;
      wrap <= 1'b0;
      leds <= encode(mode, '0, '0);
    end else if (load) begin
      cnt  <= load_val;
      pos  <= '0;
      dir  <= DIR_UP;
      step <= 1'b0;
      wrap <= 1'b0;
      leds <= encode(mode, load_val, '0);
    end else begin
      cnt  <= cnt_n;
      pos  <= pos_n;
      dir  <= dir_n;
      step <= tick;
      wrap <= wrap_n;
      leds <= encode(mode, cnt_n, pos_n);
    end
  end

endmodule
